// File: rtl/truth_table_checker.sv
// truth_table_checker: on-chip stimulus/response harness for small combinational DUTs.
// Sweeps stim over 0..2^N_INPUTS-1. Each vector is held for SETTLE_CYCLES+1 cycles,
// and resp is sampled on the last of those cycles and compared against EXPECTED[stim].
// Mismatches are counted in a saturating counter, and done/pass are reported at the end.
// Optional feature macro: FIRST_FAIL_EN adds the first_fail/fail_seen capture ports.
module truth_table_checker #(
    parameter int unsigned                  N_INPUTS      = 3,
    parameter logic [(1<<N_INPUTS)-1:0]     EXPECTED      = 8'b0111_1111,
    parameter int unsigned                  SETTLE_CYCLES = 2,
    parameter int unsigned                  ERR_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_INPUTS-1:0] stim,
    input  logic                resp,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    error_count
`ifdef FIRST_FAIL_EN
    ,
    output logic [N_INPUTS-1:0] first_fail,
    output logic                fail_seen
`endif
);

    localparam int unsigned         CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] stim_q, stim_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ERR_W-1:0]    err_next;
    logic                mismatch;
`ifdef FIRST_FAIL_EN
    logic [N_INPUTS-1:0] first_fail_q, first_fail_d;
    logic                fail_seen_q, fail_seen_d;
`endif

    // State and output registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stim_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
`ifdef FIRST_FAIL_EN
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
`ifdef FIRST_FAIL_EN
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
`endif
        end
    end

    // Next-state logic: start sweep, settle/compare/advance, then a one-cycle done.
    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        err_next     = err_q;
        mismatch     = 1'b0;
`ifdef FIRST_FAIL_EN
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    stim_d       = '0;
                    cnt_d        = CNT_INIT;
                    busy_d       = 1'b1;
                    err_d        = '0;
                    pass_d       = 1'b0;
`ifdef FIRST_FAIL_EN
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
`endif
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // X/Z on resp must count as a failure, hence the case inequality.
                    mismatch = (resp !== EXPECTED[stim_q]);
                    if (mismatch && (err_q != '1)) begin
                        err_next = err_q + ERR_W'(1);
                    end
                    err_d = err_next;
`ifdef FIRST_FAIL_EN
                    if (mismatch && !fail_seen_q) begin
                        first_fail_d = stim_q;
                        fail_seen_d  = 1'b1;
                    end
`endif
                    if (stim_q != '1) begin
                        stim_d = stim_q + N_INPUTS'(1);
                        cnt_d  = CNT_INIT;
                    end else begin
                        // pass uses err_next so the last vector's compare is included.
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_next == '0);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stim        = stim_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign error_count = err_q;
`ifdef FIRST_FAIL_EN
    assign first_fail  = first_fail_q;
    assign fail_seen   = fail_seen_q;
`endif

endmodule
